spi_frame_master: RTL and testbench

FPGA-side SPI initiator that serializes one parallel frame onto sck/mosi/ce, MSB first, and simultaneously captures a frame from miso. It is the transmitting end of the frame link our SPI receiver and display controller consume: ce high for the whole frame, sck idle low, data valid across each rising sck edge. It drives the receiver for on-chip loopback and self-test, and returns status frames to the MCU link.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_frame_master_if.sv | 30 +++
 rtl/spi_tick_gen.sv | 30 +++
 rtl/spi_frame_master.sv | 134 +++++++++++++
 tb/tb_spi_frame_master.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI frame initiator and its sibling SPI blocks.
package spi_pkg;

    localparam int SPI_FRAME_BITS = 512;
    localparam int SPI_CLK_DIV    = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HIGH,
        SCK_LOW,
        HOLD,
        DONE
    } spi_state_t;

endpackage

// File: rtl/spi_frame_master_if.sv
// Frame-level and serial-line signals of the SPI frame initiator.
interface spi_frame_master_if
    import spi_pkg::*;
#(
    parameter int FRAME_BITS = SPI_FRAME_BITS
);

    // Handshake: start is only sampled while idle. busy rises on the accept edge, and
    // done pulses for one cycle when rx_frame is updated.
    logic                  start;
    logic [FRAME_BITS-1:0] tx_frame;
    logic                  miso;
    logic                  sck;
    logic                  mosi;
    logic                  ce;
    logic [FRAME_BITS-1:0] rx_frame;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, tx_frame, miso,
        output sck, mosi, ce, rx_frame, busy, done
    );

    modport slave (
        output start, tx_frame, miso,
        input  sck, mosi, ce, rx_frame, busy, done
    );

endinterface

// File: rtl/spi_tick_gen.sv
// Phase divider: div_cnt counts 0..CLK_DIV-1 and tick marks the last cycle of each phase.
module spi_tick_gen #(
    parameter int CLK_DIV = 1,
    localparam int DIV_W  = $clog2(CLK_DIV + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    output logic             o_tick,
    output logic [DIV_W-1:0] o_div_cnt
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign o_tick    = (r_div_cnt == LAST);
    assign o_div_cnt = r_div_cnt;

endmodule

// File: rtl/spi_frame_master.sv
// SPI initiator: shifts one frame out MSB first on sck/mosi/ce and captures miso into rx_frame.
module spi_frame_master
    import spi_pkg::*;
#(
    parameter int FRAME_BITS = SPI_FRAME_BITS,
    parameter int CLK_DIV    = SPI_CLK_DIV
) (
    input  logic                      clk,
    input  logic                      reset,
    spi_frame_master_if.master        bus,
    output spi_state_t                o_state
);

    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS);

    spi_state_t            r_state;
    logic [FRAME_BITS-1:0] r_tx_shift;
    logic [FRAME_BITS-1:0] r_rx_shift;
    logic [FRAME_BITS-1:0] r_rx_frame;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic                  r_sck;
    logic                  r_mosi;
    logic                  r_ce;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_tick;
    logic                  w_first;
    logic                  w_div_clear;
    logic [DIV_W-1:0]      w_div_cnt;

    // Holding the divider cleared while idle aligns every phase to the accept edge.
    assign w_div_clear = (r_state == IDLE);
    assign w_first     = (w_div_cnt == '0);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_div_clear),
        .o_tick    (w_tick),
        .o_div_cnt (w_div_cnt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_frame <= '0;
            r_bit_cnt  <= '0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_ce       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sck  <= 1'b0;
                    r_ce   <= 1'b0;
                    r_mosi <= 1'b0;
                    if (bus.start) begin
                        r_tx_shift <= bus.tx_frame;
                        r_mosi     <= bus.tx_frame[FRAME_BITS-1];
                        r_ce       <= 1'b1;
                        r_busy     <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_sck   <= 1'b1;
                        r_state <= SCK_HIGH;
                    end
                end
                SCK_HIGH: begin
                    if (w_first) begin
                        r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], bus.miso};
                    end
                    // Advancing the data on the falling transition keeps mosi steady
                    // for a full half-period on both sides of the next rising edge.
                    if (w_tick) begin
                        r_sck      <= 1'b0;
                        r_tx_shift <= r_tx_shift << 1;
                        r_mosi     <= r_tx_shift[FRAME_BITS-2];
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        r_state    <= SCK_LOW;
                    end
                end
                SCK_LOW: begin
                    if (w_tick) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= HOLD;
                        end else begin
                            r_sck   <= 1'b1;
                            r_state <= SCK_HIGH;
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_ce       <= 1'b0;
                        r_mosi     <= 1'b0;
                        r_done     <= 1'b1;
                        r_rx_frame <= r_rx_shift;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sck      = r_sck;
    assign bus.mosi     = r_mosi;
    assign bus.ce       = r_ce;
    assign bus.rx_frame = r_rx_frame;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign o_state      = r_state;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: a 512-bit/div-1 instance and an 8-bit/div-3 instance.
`timescale 1ns/1ps
module tb_spi_frame_master;
    import spi_pkg::*;

    localparam int NA = 512;
    localparam int DA = 1;
    localparam int NB = 8;
    localparam int DB = 3;
    localparam int DONE_A = 2 * DA * (NA + 1) + 1;
    localparam int DONE_B = 2 * DB * (NB + 1) + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spi_frame_master_if #(.FRAME_BITS(NA)) bus_a ();
    spi_frame_master_if #(.FRAME_BITS(NB)) bus_b ();
    spi_state_t state_a;
    spi_state_t state_b;

    logic loop_en  = 1'b0;
    logic miso_val = 1'b0;
    assign bus_a.miso = loop_en ? bus_a.mosi : miso_val;
    assign bus_b.miso = bus_b.mosi;

    spi_frame_master #(.FRAME_BITS(NA), .CLK_DIV(DA)) dut_a (
        .clk (clk), .reset (reset), .bus (bus_a), .o_state (state_a)
    );
    spi_frame_master #(.FRAME_BITS(NB), .CLK_DIV(DB)) dut_b (
        .clk (clk), .reset (reset), .bus (bus_b), .o_state (state_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [NA-1:0] exp_q[$];

    function automatic logic [NA-1:0] rand_frame();
        logic [NA-1:0] v;
        for (int i = 0; i < NA / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Monitor for instance A: call with start already driven at a negedge while idle.
    // Cycle 1 is the first cycle after the accept edge; returns in the done cycle.
    task automatic capture_a(input bit drop_start, input bit rand_miso,
                             output logic [NA-1:0] mosi_bits, output logic [NA-1:0] miso_bits,
                             output int n_rise, output int done_cyc, output int ctl_bad,
                             output int mosi_unstable, output logic [NA-1:0] rx_at_done);
        logic prev_sck;
        logic prev_mosi;
        int   cyc;
        mosi_bits = '0; miso_bits = '0; rx_at_done = '0;
        n_rise = 0; done_cyc = -1; ctl_bad = 0; mosi_unstable = 0;
        prev_sck = 1'b0; prev_mosi = 1'b0; cyc = 0;
        @(posedge clk);
        while (cyc < DONE_A + 200) begin
            @(negedge clk);
            cyc++;
            if (drop_start) bus_a.start = 1'b0;
            if (cyc == 300) bus_a.tx_frame = ~bus_a.tx_frame;
            if (rand_miso) miso_val = 1'($urandom_range(0, 1));
            if (bus_a.done === 1'b1) begin
                done_cyc   = cyc;
                rx_at_done = bus_a.rx_frame;
                if (bus_a.ce !== 1'b0 || bus_a.busy !== 1'b1) ctl_bad++;
                break;
            end
            if (bus_a.ce !== 1'b1 || bus_a.busy !== 1'b1) ctl_bad++;
            if (bus_a.sck === 1'b1 && prev_sck === 1'b0) begin
                if (n_rise < NA) begin
                    mosi_bits[NA-1-n_rise] = bus_a.mosi;
                    miso_bits[NA-1-n_rise] = loop_en ? bus_a.mosi : miso_val;
                end
                if (prev_mosi !== bus_a.mosi) mosi_unstable++;
                n_rise++;
            end
            prev_sck  = bus_a.sck;
            prev_mosi = bus_a.mosi;
        end
    endtask

    task automatic test_reset();
        bus_a.start = 1'b1; bus_b.start = 1'b1;
        bus_a.tx_frame = rand_frame(); bus_b.tx_frame = 8'hFF;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus_a.sck, bus_a.ce, bus_a.mosi, bus_a.busy, bus_a.done} !== 5'b0 ||
                bus_a.rx_frame !== '0 || state_a !== IDLE) begin
                n_fail++;
                $display("FAIL reset_hold_a: sck/ce/mosi/busy/done=%b state=%0d expected 00000 state 0",
                         {bus_a.sck, bus_a.ce, bus_a.mosi, bus_a.busy, bus_a.done}, state_a);
            end
            n_checks++;
            if ({bus_b.sck, bus_b.ce, bus_b.mosi, bus_b.busy, bus_b.done} !== 5'b0 ||
                bus_b.rx_frame !== '0) begin
                n_fail++;
                $display("FAIL reset_hold_b: sck/ce/mosi/busy/done=%b rx=%h expected all zero",
                         {bus_b.sck, bus_b.ce, bus_b.mosi, bus_b.busy, bus_b.done}, bus_b.rx_frame);
            end
        end
        bus_a.start = 1'b0; bus_b.start = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_a.ce !== 1'b0 || bus_a.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ce=%b busy=%b expected 0 0", bus_a.ce, bus_a.busy);
        end
    endtask

    task automatic test_fc_pattern();
        logic [NA-1:0] tx, mb, ib, rx;
        int nr, dc, cb, mu;
        tx = {(NA / 8){8'hFC}};
        bus_a.tx_frame = tx; bus_a.start = 1'b1;
        capture_a(1'b1, 1'b1, mb, ib, nr, dc, cb, mu, rx);
        n_checks++;
        if (nr !== NA) begin n_fail++; $display("FAIL fc_rises: got %0d expected %0d", nr, NA); end
        n_checks++;
        if (mb !== tx) begin n_fail++; $display("FAIL fc_mosi: got %h expected %h", mb, tx); end
        n_checks++;
        if (dc !== DONE_A) begin n_fail++; $display("FAIL fc_done_cycle: got %0d expected %0d", dc, DONE_A); end
        n_checks++;
        if (cb !== 0) begin n_fail++; $display("FAIL fc_ce_busy: %0d bad cycles expected 0", cb); end
        n_checks++;
        if (mu !== 0) begin n_fail++; $display("FAIL fc_mosi_setup: %0d unstable bits expected 0", mu); end
        n_checks++;
        if (rx !== ib) begin n_fail++; $display("FAIL fc_rx: got %h expected %h", rx, ib); end
        @(negedge clk);
        n_checks++;
        if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0 || state_a !== IDLE || bus_a.rx_frame !== ib) begin
            n_fail++;
            $display("FAIL fc_after_done: done=%b busy=%b state=%0d expected 0 0 IDLE with rx held",
                     bus_a.done, bus_a.busy, state_a);
        end
    endtask

    task automatic test_loopback();
        logic [NA-1:0] tx, mb, ib, rx;
        int nr, dc, cb, mu;
        for (int i = 0; i < NA / 8; i++) tx[NA-1-8*i -: 8] = 8'(4 * i);
        loop_en = 1'b1;
        @(negedge clk);
        bus_a.tx_frame = tx; bus_a.start = 1'b1;
        capture_a(1'b1, 1'b0, mb, ib, nr, dc, cb, mu, rx);
        n_checks++;
        if (rx !== tx) begin n_fail++; $display("FAIL loop_rx: got %h expected %h", rx, tx); end
        n_checks++;
        if (mb !== tx) begin n_fail++; $display("FAIL loop_receiver: got %h expected %h", mb, tx); end
        n_checks++;
        if (dc !== DONE_A) begin n_fail++; $display("FAIL loop_done_cycle: got %0d expected %0d", dc, DONE_A); end
        loop_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [NA-1:0] tx, mb, ib, rx, exp_tx;
        int nr, dc, cb, mu;
        for (int f = 0; f < 3; f++) begin
            tx = rand_frame();
            exp_q.push_back(tx);
            bus_a.tx_frame = tx; bus_a.start = 1'b1;
            capture_a(1'b1, 1'b1, mb, ib, nr, dc, cb, mu, rx);
            exp_tx = exp_q.pop_front();
            n_checks++;
            if (mb !== exp_tx) begin n_fail++; $display("FAIL rand_mosi[%0d]: got %h expected %h", f, mb, exp_tx); end
            n_checks++;
            if (rx !== ib) begin n_fail++; $display("FAIL rand_rx[%0d]: got %h expected %h", f, rx, ib); end
            n_checks++;
            if (nr !== NA || dc !== DONE_A || cb !== 0) begin
                n_fail++;
                $display("FAIL rand_timing[%0d]: rises=%0d done=%0d bad=%0d expected %0d %0d 0",
                         f, nr, dc, cb, NA, DONE_A);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [NA-1:0] tx, mb, ib, rx;
        int nr, dc, cb, mu;
        tx = rand_frame();
        bus_a.tx_frame = tx; bus_a.start = 1'b1;
        capture_a(1'b0, 1'b1, mb, ib, nr, dc, cb, mu, rx);
        n_checks++;
        if (mb !== tx || dc !== DONE_A) begin
            n_fail++;
            $display("FAIL b2b_first: mosi %h done %0d expected %h %0d", mb, dc, tx, DONE_A);
        end
        @(negedge clk);
        n_checks++;
        if (bus_a.ce !== 1'b0 || bus_a.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: ce=%b busy=%b expected 0 0", bus_a.ce, bus_a.busy);
        end
        capture_a(1'b0, 1'b1, mb, ib, nr, dc, cb, mu, rx);
        bus_a.start = 1'b0;
        n_checks++;
        if (mb !== ~tx) begin n_fail++; $display("FAIL b2b_second_mosi: got %h expected %h", mb, ~tx); end
        n_checks++;
        if (dc !== DONE_A || cb !== 0 || rx !== ib) begin
            n_fail++;
            $display("FAIL b2b_second: done=%0d bad=%0d expected %0d 0 and rx match", dc, cb, DONE_A);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_a.ce !== 1'b0 || state_a !== IDLE) begin
            n_fail++;
            $display("FAIL b2b_stop: ce=%b state=%0d expected 0 IDLE", bus_a.ce, state_a);
        end
    endtask

    task automatic test_reset_midframe();
        logic [NA-1:0] tx, mb, ib, rx;
        int nr, dc, cb, mu, rises, done_seen, ce_seen;
        logic prev_sck;
        bus_a.tx_frame = rand_frame(); bus_a.start = 1'b1;
        @(posedge clk);
        rises = 0; prev_sck = 1'b0;
        for (int c = 0; c < DONE_A && rises < 100; c++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            if (bus_a.sck === 1'b1 && prev_sck === 1'b0) rises++;
            prev_sck = bus_a.sck;
        end
        n_checks++;
        if (rises !== 100) begin n_fail++; $display("FAIL rst_mid_reach: got %0d rises expected 100", rises); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_a.sck, bus_a.ce, bus_a.mosi, bus_a.busy, bus_a.done} !== 5'b0 ||
            bus_a.rx_frame !== '0 || state_a !== IDLE) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: sck/ce/mosi/busy/done=%b rx_nonzero=%b expected 00000 0",
                     {bus_a.sck, bus_a.ce, bus_a.mosi, bus_a.busy, bus_a.done}, |bus_a.rx_frame);
        end
        reset = 1'b1;
        done_seen = 0; ce_seen = 0;
        for (int c = 0; c < DONE_A + 20; c++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) done_seen++;
            if (bus_a.ce === 1'b1) ce_seen++;
        end
        n_checks++;
        if (done_seen !== 0 || ce_seen !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: done=%0d ce=%0d cycles expected 0 0", done_seen, ce_seen);
        end
        tx = rand_frame();
        bus_a.tx_frame = tx; bus_a.start = 1'b1;
        capture_a(1'b1, 1'b1, mb, ib, nr, dc, cb, mu, rx);
        n_checks++;
        if (nr !== NA || mb !== tx || dc !== DONE_A || rx !== ib) begin
            n_fail++;
            $display("FAIL rst_mid_fresh: rises=%0d done=%0d mosi %h expected %0d %0d %h",
                     nr, dc, mb, NA, DONE_A, tx);
        end
        @(negedge clk);
    endtask

    task automatic test_div3();
        int rise_q[$];
        int fall_q[$];
        logic [NB-1:0] mb;
        logic prev_sck;
        int cyc, dc;
        mb = '0; prev_sck = 1'b0; cyc = 0; dc = -1;
        bus_b.tx_frame = 8'hA5; bus_b.start = 1'b1;
        @(posedge clk);
        while (cyc < DONE_B + 40) begin
            @(negedge clk);
            cyc++;
            bus_b.start = 1'b0;
            if (bus_b.done === 1'b1) begin dc = cyc; break; end
            if (bus_b.sck === 1'b1 && prev_sck === 1'b0) begin
                if (rise_q.size() < NB) mb[NB-1-rise_q.size()] = bus_b.mosi;
                rise_q.push_back(cyc);
            end
            if (bus_b.sck === 1'b0 && prev_sck === 1'b1) fall_q.push_back(cyc);
            prev_sck = bus_b.sck;
        end
        n_checks++;
        if (rise_q.size() !== NB || fall_q.size() !== NB) begin
            n_fail++;
            $display("FAIL div3_edges: rises=%0d falls=%0d expected %0d %0d", rise_q.size(), fall_q.size(), NB, NB);
        end
        for (int k = 0; k < NB && k < rise_q.size() && k < fall_q.size(); k++) begin
            n_checks++;
            if (rise_q[k] !== DB * (1 + 2 * k) + 1 || fall_q[k] !== DB * (2 + 2 * k) + 1) begin
                n_fail++;
                $display("FAIL div3_edge[%0d]: rise %0d fall %0d expected %0d %0d", k, rise_q[k], fall_q[k],
                         DB * (1 + 2 * k) + 1, DB * (2 + 2 * k) + 1);
            end
        end
        n_checks++;
        if (mb !== 8'hA5) begin n_fail++; $display("FAIL div3_mosi: got %b expected 10100101", mb); end
        n_checks++;
        if (dc !== DONE_B) begin n_fail++; $display("FAIL div3_done_cycle: got %0d expected %0d", dc, DONE_B); end
        n_checks++;
        if (bus_b.rx_frame !== 8'hA5) begin
            n_fail++;
            $display("FAIL div3_rx: got %h expected a5", bus_b.rx_frame);
        end
        @(negedge clk);
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.tx_frame = '0;
        bus_b.start = 1'b0; bus_b.tx_frame = '0;
        @(negedge clk);
        test_reset();
        test_fc_pattern();
        test_loopback();
        test_random();
        test_back_to_back();
        test_reset_midframe();
        test_div3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
